// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection, PC register, fetch gating, misaligned-target trap and retire counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter logic [31:0] INSTRET_INIT = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        branch_taken_i,
  input  logic        jal_i,
  input  logic        jalr_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_data_i,
  input  logic        imem_ready_i,
  input  logic        stall_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        imem_req_o,
  output logic        retire_o,
  output logic        trap_o,
  output logic [31:0] trap_epc_o,
  output logic [31:0] instret_o
);
  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
  state_t      state_q;
  logic [31:0] pc_q, pc_d, trap_epc_q, instret_q;
  logic        imem_req_q, trap_q, attempt, misaligned;
  always_comb begin
    pc_plus4_o = pc_q + 32'd4;
    pc_d       = jalr_i ? ((rs1_data_i + imm_i) & ~32'h1) :
                 (jal_i | branch_taken_i) ? (pc_q + imm_i) : pc_plus4_o;
    misaligned = (jalr_i | jal_i | branch_taken_i) & pc_d[1];
    attempt    = (state_q == RUN) & imem_ready_i & ~stall_i;
    retire_o   = attempt & ~misaligned;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      imem_req_q <= 1'b0;
      trap_q     <= 1'b0;
      trap_epc_q <= 32'h0;
      instret_q  <= INSTRET_INIT;
    end else begin
      case (state_q)
        BOOT: begin
          state_q    <= RUN;
          imem_req_q <= 1'b1;
        end
        RUN: if (attempt) begin
          if (misaligned) begin
            // Faulting instruction does not commit; PC stays on it for trap_epc.
            trap_epc_q <= pc_q;
            trap_q     <= 1'b1;
            imem_req_q <= 1'b0;
            state_q    <= TRAP;
          end else begin
            pc_q      <= pc_d;
            instret_q <= instret_q + 32'd1;
          end
        end
        TRAP: begin
          pc_q       <= TRAP_VECTOR;
          trap_q     <= 1'b0;
          imem_req_q <= 1'b1;
          state_q    <= RUN;
        end
        default: state_q <= BOOT;
      endcase
    end
  end
  assign pc_o       = pc_q;
  assign imem_req_o = imem_req_q;
  assign trap_o     = trap_q;
  assign trap_epc_o = trap_epc_q;
  assign instret_o  = instret_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors; expectations queued by the stimulus and checked by an independent monitor.
module tb_pc_sequencer;
  logic        clk, rst, br, jl, jr, rdy, stl;
  logic [31:0] imm, rs1;
  logic [31:0] pc, pc4, epc, inst, w_pc, w_pc4, w_epc, w_inst;
  logic        req, ret, trp, w_req, w_ret, w_trp;
  int tests = 0;
  int fails = 0;
  typedef struct {
    string       nm;
    logic        ret;
    logic [31:0] pc;
    logic        req;
    logic        trp;
    logic [31:0] epc;
    logic [31:0] inst;
  } exp_t;
  exp_t q[$];
  pc_sequencer dut (
    .clk_i(clk), .reset_i(rst), .branch_taken_i(br), .jal_i(jl), .jalr_i(jr),
    .imm_i(imm), .rs1_data_i(rs1), .imem_ready_i(rdy), .stall_i(stl),
    .pc_o(pc), .pc_plus4_o(pc4), .imem_req_o(req), .retire_o(ret),
    .trap_o(trp), .trap_epc_o(epc), .instret_o(inst)
  );
  pc_sequencer #(.INSTRET_INIT(32'hFFFF_FFFF)) u_wrap (
    .clk_i(clk), .reset_i(rst), .branch_taken_i(br), .jal_i(jl), .jalr_i(jr),
    .imm_i(imm), .rs1_data_i(rs1), .imem_ready_i(rdy), .stall_i(stl),
    .pc_o(w_pc), .pc_plus4_o(w_pc4), .imem_req_o(w_req), .retire_o(w_ret),
    .trap_o(w_trp), .trap_epc_o(w_epc), .instret_o(w_inst)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endfunction
  // Drives one cycle of inputs at a falling edge and queues what that cycle must produce.
  task automatic step(string nm, logic r, logic s, logic b, logic j, logic jlr,
                      logic [31:0] im, logic [31:0] rs, logic er, logic [31:0] ep,
                      logic eq, logic et, logic [31:0] ee, logic [31:0] ei);
    exp_t e;
    rdy = r; stl = s; br = b; jl = j; jr = jlr; imm = im; rs1 = rs;
    e = '{nm, er, ep, eq, et, ee, ei};
    q.push_back(e);
    @(negedge clk);
  endtask
  task automatic idle();
    rdy = 0; stl = 0; br = 0; jl = 0; jr = 0; imm = 0; rs1 = 0;
  endtask
  task automatic chk_reset(string nm);
    chk({nm, ".pc"}, pc, 32'h0);
    chk({nm, ".req"}, {31'h0, req}, 32'h0);
    chk({nm, ".trap"}, {31'h0, trp}, 32'h0);
    chk({nm, ".epc"}, epc, 32'h0);
    chk({nm, ".instret"}, inst, 32'h0);
    chk({nm, ".retire"}, {31'h0, ret}, 32'h0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q[0];
        chk({e.nm, ".retire"}, {31'h0, ret}, {31'h0, e.ret});
        @(posedge clk);
        #1;
        chk({e.nm, ".pc"}, pc, e.pc);
        chk({e.nm, ".pc_plus4"}, pc4, e.pc + 32'd4);
        chk({e.nm, ".req"}, {31'h0, req}, {31'h0, e.req});
        chk({e.nm, ".trap"}, {31'h0, trp}, {31'h0, e.trp});
        chk({e.nm, ".epc"}, epc, e.epc);
        chk({e.nm, ".instret"}, inst, e.inst);
        void'(q.pop_front());
      end
    end
  end
  initial begin
    idle();
    rst = 0;
    #1 rst = 1;
    @(negedge clk);
    chk_reset("por");
    chk("wrap.init", w_inst, 32'hFFFF_FFFF);
    rst = 0;
    step("boot",   0,0,0,0,0, 32'h0, 32'h0,        0, 32'h0,  1,0, 32'h0, 32'd0);
    step("seq1",   1,0,0,0,0, 32'h0, 32'h0,        1, 32'h4,  1,0, 32'h0, 32'd1);
    chk("wrap.instret", w_inst, 32'h0);
    step("stall",  1,1,0,0,0, 32'h0, 32'h0,        0, 32'h4,  1,0, 32'h0, 32'd1);
    step("seq3",   1,0,0,0,0, 32'h0, 32'h0,        1, 32'h8,  1,0, 32'h0, 32'd2);
    step("seq4",   1,0,0,0,0, 32'h0, 32'h0,        1, 32'hC,  1,0, 32'h0, 32'd3);
    step("jal20",  1,0,0,1,0, 32'h14, 32'h0,       1, 32'h20, 1,0, 32'h0, 32'd4);
    step("prio",   1,0,1,1,1, 32'h10, 32'h101,     1, 32'h110,1,0, 32'h0, 32'd5);
    step("jalr20", 1,0,0,0,1, 32'h0, 32'h20,       1, 32'h20, 1,0, 32'h0, 32'd6);
    step("brjal",  1,0,1,1,0, 32'h10, 32'h101,     1, 32'h30, 1,0, 32'h0, 32'd7);
    step("br40",   1,0,1,0,0, 32'h10, 32'h0,       1, 32'h40, 1,0, 32'h0, 32'd8);
    step("trap",   1,0,0,1,0, 32'h6, 32'h0,        0, 32'h40, 0,1, 32'h40, 32'd8);
    step("tvec",   1,0,0,1,0, 32'h6, 32'h0,        0, 32'h100,1,0, 32'h40, 32'd8);
    step("stlmis", 1,1,1,0,0, 32'h2, 32'h0,        0, 32'h100,1,0, 32'h40, 32'd8);
    for (int i = 0; i < 3; i++)
      step("nordy", 0,0,1,0,0, 32'h8, 32'h0,       0, 32'h100,1,0, 32'h40, 32'd8);
    step("jalrtop",1,0,0,0,1, 32'h0, 32'hFFFF_FFFD,1, 32'hFFFF_FFFC,1,0, 32'h40, 32'd9);
    step("wrap",   1,0,0,0,0, 32'h0, 32'h0,        1, 32'h0,  1,0, 32'h40, 32'd10);
    step("jal40",  1,0,0,1,0, 32'h40, 32'h0,       1, 32'h40, 1,0, 32'h40, 32'd11);
    idle();
    #3 rst = 1;
    #1 chk_reset("rst_run");
    @(negedge clk);
    rst = 0;
    step("boot2",  0,0,0,0,0, 32'h0, 32'h0,        0, 32'h0,  1,0, 32'h0, 32'd0);
    step("seq5",   1,0,0,0,0, 32'h0, 32'h0,        1, 32'h4,  1,0, 32'h0, 32'd1);
    step("jalrmis",1,0,0,0,1, 32'h2, 32'h100,      0, 32'h4,  0,1, 32'h4, 32'd1);
    idle();
    #3 rst = 1;
    #1 chk_reset("rst_trap");
    @(negedge clk);
    rst = 0;
    step("boot3",  0,0,0,0,0, 32'h0, 32'h0,        0, 32'h0,  1,0, 32'h0, 32'd0);
    step("seq6",   1,0,0,0,0, 32'h0, 32'h0,        1, 32'h4,  1,0, 32'h0, 32'd1);
    idle();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
